// File: rtl/activation_pkg.sv
// Shared definitions for the activation unit: function-select encoding
// and the saturating clip-counter arithmetic.
package activation_pkg;

   typedef enum logic [1:0] {
      ACT_PASS  = 2'd0,
      ACT_RELU  = 2'd1,
      ACT_LEAKY = 2'd2,
      ACT_CLIP  = 2'd3
   } act_mode_e;

   localparam int CLIP_CNT_W = 16;

   // Add without wrapping: once the counter tops out it sticks at all-ones.
   function automatic logic [CLIP_CNT_W-1:0] clip_sat_add(
      input logic [CLIP_CNT_W-1:0] base,
      input logic [CLIP_CNT_W-1:0] inc
   );
      logic [CLIP_CNT_W:0] sum;
      sum = {1'b0, base} + {1'b0, inc};
      return sum[CLIP_CNT_W] ? {CLIP_CNT_W{1'b1}} : sum[CLIP_CNT_W-1:0];
   endfunction

endpackage

// File: rtl/act_lane.sv
// One lane of the activation function: purely combinational, signed
// two's-complement in, result plus a flag saying the CLIP_MAX ceiling bit.
module act_lane
   import activation_pkg::*;
#(
   parameter int                DATA_W     = 32,
   parameter int                LEAK_SHIFT = 3,
   parameter logic [DATA_W-1:0] CLIP_MAX   = 32'h0006_0000
) (
   input  logic [DATA_W-1:0] value,
   input  logic [1:0]        mode,
   output logic [DATA_W-1:0] result,
   output logic              clipped
);

   logic signed [DATA_W-1:0] value_s;
   logic signed [DATA_W-1:0] clip_max_s;
   logic                     is_neg;

   assign value_s    = value;
   assign clip_max_s = CLIP_MAX;
   assign is_neg     = value_s[DATA_W-1];

   always_comb begin
      // NOTE: every output gets a default before the case so no path can leave it unassigned (no latch).
      result  = value;
      clipped = 1'b0;
      unique case (act_mode_e'(mode))
         ACT_PASS:  ;
         ACT_RELU:  if (is_neg) result = '0;
         ACT_LEAKY: if (is_neg) result = value_s >>> LEAK_SHIFT;
         ACT_CLIP: begin
            if (is_neg) begin
               result = '0;
            end else if (value_s > clip_max_s) begin
               result  = CLIP_MAX;
               clipped = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/activation_unit.sv
// Two-stage valid/ready activation pipeline: S1 registers the input beat,
// S2 registers the per-lane results; also reports end-of-vector and clip statistics.
module activation_unit
   import activation_pkg::*;
#(
   parameter int                DATA_W     = 32,
   parameter int                LANES      = 4,
   parameter int                LEAK_SHIFT = 3,
   parameter logic [DATA_W-1:0] CLIP_MAX   = 32'h0006_0000
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic [LANES*DATA_W-1:0] act_in,
   input  logic [1:0]              act_mode,
   input  logic                    act_valid,
   input  logic                    act_last,
   output logic                    act_ready,
   output logic [LANES*DATA_W-1:0] act_out,
   output logic                    act_out_valid,
   input  logic                    act_out_ready,
   output logic                    act_done,
   output logic [15:0]             clip_count
);

   localparam int BEAT_W  = LANES * DATA_W;
   localparam int NCLIP_W = $clog2(LANES + 1);

   logic                  ready_en_q, ready_en_d;
   logic                  s1_valid_q, s1_valid_d;
   logic [BEAT_W-1:0]     s1_data_q,  s1_data_d;
   logic [1:0]            s1_mode_q,  s1_mode_d;
   logic                  s1_last_q,  s1_last_d;
   logic                  s2_valid_q, s2_valid_d;
   logic [BEAT_W-1:0]     s2_data_q,  s2_data_d;
   logic                  s2_last_q,  s2_last_d;
   logic [NCLIP_W-1:0]    s2_nclip_q, s2_nclip_d;
   logic                  done_q,     done_d;
   logic [CLIP_CNT_W-1:0] clip_q,     clip_d;

   logic [BEAT_W-1:0]     lane_result;
   logic [LANES-1:0]      lane_clipped;
   logic [NCLIP_W-1:0]    lane_nclip;
   logic                  s2_load;
   logic                  out_hs;
   logic [CLIP_CNT_W-1:0] clip_base;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      act_lane #(
         .DATA_W     (DATA_W),
         .LEAK_SHIFT (LEAK_SHIFT),
         .CLIP_MAX   (CLIP_MAX)
      ) u_lane (
         .value   (s1_data_q[i*DATA_W +: DATA_W]),
         .mode    (s1_mode_q),
         .result  (lane_result[i*DATA_W +: DATA_W]),
         .clipped (lane_clipped[i])
      );
   end

   always_comb begin
      lane_nclip = '0;
      for (int i = 0; i < LANES; i++) begin
         lane_nclip = lane_nclip + NCLIP_W'(lane_clipped[i]);
      end
   end

   always_comb begin
      s2_load   = !s2_valid_q || act_out_ready;
      out_hs    = s2_valid_q && act_out_ready;
      // ready_en_q keeps the input closed until the first edge after reset releases.
      act_ready = ready_en_q && (!s1_valid_q || s2_load);

      ready_en_d = 1'b1;
      s1_valid_d = s1_valid_q;
      s1_data_d  = s1_data_q;
      s1_mode_d  = s1_mode_q;
      s1_last_d  = s1_last_q;
      s2_valid_d = s2_valid_q;
      s2_data_d  = s2_data_q;
      s2_last_d  = s2_last_q;
      s2_nclip_d = s2_nclip_q;

      if (act_ready) begin
         s1_valid_d = act_valid;
         s1_data_d  = act_in;
         s1_mode_d  = act_mode;
         s1_last_d  = act_last;
      end

      if (s2_load) begin
         s2_valid_d = s1_valid_q;
         s2_data_d  = lane_result;
         s2_last_d  = s1_last_q;
         s2_nclip_d = lane_nclip;
      end

      done_d = out_hs && s2_last_q;

      // The clear on the done cycle happens first, so a beat leaving in that cycle lands on zero.
      clip_base = done_q ? '0 : clip_q;
      clip_d    = out_hs ? clip_sat_add(clip_base, CLIP_CNT_W'(s2_nclip_q)) : clip_base;
   end

   // NOTE: all flops, data registers included, are reset so act_out reads zero while reset_n is low.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ready_en_q <= 1'b0;
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_mode_q  <= '0;
         s1_last_q  <= 1'b0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_last_q  <= 1'b0;
         s2_nclip_q <= '0;
         done_q     <= 1'b0;
         clip_q     <= '0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge value of the others.
         ready_en_q <= ready_en_d;
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
         s1_mode_q  <= s1_mode_d;
         s1_last_q  <= s1_last_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
         s2_last_q  <= s2_last_d;
         s2_nclip_q <= s2_nclip_d;
         done_q     <= done_d;
         clip_q     <= clip_d;
      end
   end

   assign act_out       = s2_data_q;
   assign act_out_valid = s2_valid_q;
   assign act_done      = done_q;
   assign clip_count    = clip_q;

endmodule

// File: tb/tb_activation_unit.sv
// Randomized self-checking bench for activation_unit: an arithmetic reference
// model plus a beat scoreboard, with directed vectors for the documented cases.
module tb_activation_unit;

   localparam int     DATA_W   = 32;
   localparam int     LANES    = 4;
   localparam longint CLIP     = 64'h0000_0000_0006_0000;
   localparam longint LEAK_DIV = 8;

   logic         clock;
   logic         reset_n;
   logic [127:0] act_in;
   logic [1:0]   act_mode;
   logic         act_valid;
   logic         act_last;
   logic         act_ready;
   logic [127:0] act_out;
   logic         act_out_valid;
   logic         act_out_ready;
   logic         act_done;
   logic [15:0]  clip_count;

   activation_unit dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .act_in        (act_in),
      .act_mode      (act_mode),
      .act_valid     (act_valid),
      .act_last      (act_last),
      .act_ready     (act_ready),
      .act_out       (act_out),
      .act_out_valid (act_out_valid),
      .act_out_ready (act_out_ready),
      .act_done      (act_done),
      .clip_count    (clip_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] ref_lane(input logic [31:0] x, input logic [1:0] m,
                                            output int clipped);
      longint v, r;
      v = longint'($signed(x));
      r = v;
      clipped = 0;
      case (m)
         2'd1: if (v < 0) r = 0;
         2'd2: if (v < 0) r = -((-v + LEAK_DIV - 1) / LEAK_DIV);
         2'd3: begin
            if (v < 0) r = 0;
            else if (v > CLIP) begin
               r = CLIP;
               clipped = 1;
            end
         end
         default: ;
      endcase
      return r[31:0];
   endfunction

   function automatic logic [127:0] ref_beat(input logic [127:0] d, input logic [1:0] m,
                                             output int nclip);
      logic [127:0] r;
      int c;
      nclip = 0;
      r = '0;
      for (int i = 0; i < LANES; i++) begin
         r[i*DATA_W +: DATA_W] = ref_lane(d[i*DATA_W +: DATA_W], m, c);
         nclip += c;
      end
      return r;
   endfunction

   function automatic logic [127:0] pack4(input logic [31:0] l0, input logic [31:0] l1,
                                          input logic [31:0] l2, input logic [31:0] l3);
      return {l3, l2, l1, l0};
   endfunction

   function automatic logic [31:0] rand_val();
      case ($urandom_range(0, 7))
         0: return 32'h8000_0000;
         1: return 32'h7FFF_FFFF;
         2: return 32'hFFFF_FFFF;
         3: return 32'h0006_0000;
         4: return 32'h0006_0001;
         5: return 32'($urandom_range(0, 32'h000C_0000));
         6: return -32'($urandom_range(0, 64));
         default: return $urandom();
      endcase
   endfunction

   typedef struct {
      logic [127:0] data;
      bit           last;
      int           nclip;
   } exp_t;

   exp_t         q[$];
   logic [15:0]  mclip     = '0;
   bit           exp_done  = 1'b0;
   bit           prev_stall = 1'b0;
   logic [127:0] prev_out  = '0;

   // Scoreboard: inputs are stable from the negedge to the following posedge,
   // so handshakes seen here are exactly the ones the DUT takes at the next edge.
   always @(negedge clock) begin : monitor
      bit           ohs, ihs;
      exp_t         e;
      int           tmp;
      logic [15:0]  base;
      if (!reset_n) begin
         q.delete();
         mclip      = '0;
         exp_done   = 1'b0;
         prev_stall = 1'b0;
      end else begin
         ohs = act_out_valid && act_out_ready;
         ihs = act_valid && act_ready;
         check("act_ready", act_ready, !(q.size() == 2 && !act_out_ready));
         check("act_done", act_done, exp_done);
         check("clip_count", clip_count, mclip);
         if (q.size() == 0) check("idle_out_valid", act_out_valid, 0);
         if (prev_stall) begin
            check("stall_valid", act_out_valid, 1);
            check("stall_hold", act_out, prev_out);
         end
         base     = exp_done ? 16'h0 : mclip;
         mclip    = base;
         exp_done = 1'b0;
         if (ohs && q.size() != 0) begin
            e = q.pop_front();
            check("act_out", act_out, e.data);
            tmp      = int'(base) + e.nclip;
            mclip    = (tmp > 65535) ? 16'hFFFF : tmp[15:0];
            exp_done = e.last;
         end
         if (ihs) begin
            e.data = ref_beat(act_in, act_mode, e.nclip);
            e.last = act_last;
            q.push_back(e);
         end
         prev_stall = act_out_valid && !act_out_ready;
         prev_out   = act_out;
      end
   end

   // ---------------- stimulus ----------------
   task automatic release_reset();
      @(negedge clock); #1;
      reset_n = 1'b1;
      #1 check("ready_low_before_edge", act_ready, 0);
      @(posedge clock); #1;
      check("ready_after_first_edge", act_ready, 1);
   endtask

   task automatic drain();
      act_valid     = 1'b0;
      act_out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clock); #2;
         if (q.size() == 0 && !act_out_valid) break;
      end
      check("drain_empty", q.size(), 0);
   endtask

   task automatic directed(input string tag, input logic [127:0] din, input logic [1:0] m,
                           input logic last, input logic [127:0] exp_out,
                           input logic [15:0] exp_clip);
      @(posedge clock); #1;
      act_in = din; act_mode = m; act_last = last; act_valid = 1'b1; act_out_ready = 1'b1;
      @(negedge clock);
      check({tag, "_accept"}, act_ready, 1);
      @(posedge clock); #1;
      act_valid = 1'b0;
      @(negedge clock);
      check({tag, "_lat1_valid"}, act_out_valid, 0);
      @(negedge clock);
      check({tag, "_lat2_valid"}, act_out_valid, 1);
      check({tag, "_out"}, act_out, exp_out);
      @(negedge clock);
      check({tag, "_one_cycle"}, act_out_valid, 0);
      check({tag, "_done"}, act_done, last);
      check({tag, "_clip"}, clip_count, exp_clip);
      @(negedge clock);
      check({tag, "_done_clear"}, act_done, 0);
      if (last) check({tag, "_clip_clear"}, clip_count, 0);
   endtask

   task automatic run_stream(input int n, input int pat);
      int sent, cyc;
      bit hs;
      sent = 0;
      cyc  = 0;
      @(posedge clock); #1;
      while (sent < n && cyc < 20 * n + 100) begin
         case (pat)
            0:       act_out_ready = 1'b1;
            1:       act_out_ready = (cyc % 3 == 0);
            default: act_out_ready = 1'($urandom_range(0, 1));
         endcase
         if (!act_valid && (pat != 2 || $urandom_range(0, 3) != 0)) begin
            act_in    = pack4(rand_val(), rand_val(), rand_val(), rand_val());
            act_mode  = 2'($urandom_range(0, 3));
            act_last  = ($urandom_range(0, 3) == 0);
            act_valid = 1'b1;
         end
         @(negedge clock);
         hs = act_valid && act_ready;
         @(posedge clock); #1;
         cyc++;
         if (hs) begin
            sent++;
            act_valid = 1'b0;
         end
      end
      check("stream_sent", sent, n);
      if (pat == 0) check("throughput_cycles", cyc, n);
      drain();
   endtask

   task automatic reset_mid_flight();
      @(posedge clock); #1;
      act_out_ready = 1'b0;
      act_mode      = 2'd3;
      act_in        = {4{32'h0007_0000}};
      act_last      = 1'b1;
      act_valid     = 1'b1;
      @(posedge clock); #1;
      @(posedge clock); #1;
      act_valid = 1'b0;
      @(negedge clock);
      check("full_stall_ready", act_ready, 0);
      #1 reset_n = 1'b0;
      #1;
      check("rst_out_valid", act_out_valid, 0);
      check("rst_act_out", act_out, 0);
      check("rst_clip", clip_count, 0);
      check("rst_done", act_done, 0);
      check("rst_ready", act_ready, 0);
      @(posedge clock); #1;
      check("rst_ready_held", act_ready, 0);
      release_reset();
      act_out_ready = 1'b1;
      repeat (4) @(posedge clock);
      #1 check("no_ghost_output", act_out_valid, 0);
   endtask

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "simulation time limit");
   end

   initial begin : main
      reset_n = 1'b0; act_in = '0; act_mode = '0; act_valid = 1'b0;
      act_last = 1'b0; act_out_ready = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check("por_out_valid", act_out_valid, 0);
      check("por_act_out", act_out, 0);
      check("por_done", act_done, 0);
      check("por_clip", clip_count, 0);
      check("por_ready", act_ready, 0);
      release_reset();

      directed("relu", pack4(-32'sd5, 32'd0, 32'd7, 32'h8000_0000), 2'd1, 1'b0,
               pack4(32'd0, 32'd0, 32'd7, 32'd0), 16'd0);
      directed("leaky", pack4(-32'sd16, -32'sd1, 32'd9, -32'sd8), 2'd2, 1'b0,
               pack4(-32'sd2, -32'sd1, 32'd9, -32'sd1), 16'd0);
      directed("clip", pack4(32'h0007_0000, 32'h0007_0000, 32'h0007_0000, -32'sd3), 2'd3, 1'b1,
               pack4(32'h0006_0000, 32'h0006_0000, 32'h0006_0000, 32'd0), 16'd3);

      run_stream(10, 1);
      run_stream(100, 0);
      run_stream(200, 2);

      // Saturation: 16400 beats of four clipped lanes overshoot 16'hFFFF.
      @(posedge clock); #1;
      act_mode = 2'd3; act_in = {4{32'h7FFF_FFFF}}; act_last = 1'b0;
      act_valid = 1'b1; act_out_ready = 1'b1;
      repeat (16400) @(posedge clock);
      #1;
      drain();
      check("clip_saturated", clip_count, 16'hFFFF);
      directed("clip_sat", pack4(32'h0007_0000, 32'h0007_0000, 32'h0007_0000, -32'sd3), 2'd3, 1'b1,
               pack4(32'h0006_0000, 32'h0006_0000, 32'h0006_0000, 32'd0), 16'hFFFF);

      reset_mid_flight();
      run_stream(60, 2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
